// File: rtl/alu_control_fsm.sv
// Multicycle RV32I control unit: steps the shared ALU and datapath muxes/enables
// through fetch, decode and per-class execute states, one instruction at a time.
module alu_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic        adr_src,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JAL       = 4'd10,
        LUI       = 4'd11,
        ILLEGAL   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    state_t     cur_state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign state  = cur_state;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // alt selects SUB (for 000) or SRA (for 101); callers decide when it applies
    function automatic logic [3:0] alu_op_for(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic r_legal(input logic [2:0] f3, input logic [6:0] f7);
        return (f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
    endfunction

    function automatic logic i_legal(input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'b001:  return f7 == F7_ZERO;
            3'b101:  return (f7 == F7_ZERO) || (f7 == F7_ALT);
            default: return 1'b1;
        endcase
    endfunction

    function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7);
        case (op)
            OP_LOAD, OP_STORE: return MEM_ADR;
            OP_R:              return r_legal(f3, f7) ? EXEC_R : ILLEGAL;
            OP_I:              return i_legal(f3, f7) ? EXEC_I : ILLEGAL;
            OP_BRANCH:         return (f3[2:1] == 2'b01) ? ILLEGAL : BRANCH;
            OP_JAL:            return JAL;
            OP_LUI:            return LUI;
            default:           return ILLEGAL;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= state_t'(RESET_STATE);
        end else begin
            case (cur_state)
                FETCH:     cur_state <= DECODE;
                DECODE:    cur_state <= decode_next(opcode, funct3, funct7);
                MEM_ADR:   cur_state <= (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
                MEM_READ:  cur_state <= MEM_WB;
                MEM_WB:    cur_state <= FETCH;
                MEM_WRITE: cur_state <= FETCH;
                EXEC_R:    cur_state <= ALU_WB;
                EXEC_I:    cur_state <= ALU_WB;
                ALU_WB:    cur_state <= FETCH;
                BRANCH:    cur_state <= FETCH;
                JAL:       cur_state <= ALU_WB;
                LUI:       cur_state <= ALU_WB;
                default:   cur_state <= ILLEGAL;
            endcase
        end
    end

    // Outputs are forced quiet while rst is high, since the reset state itself is FETCH
    always_comb begin
        alu_op     = ALU_ADD;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (cur_state)
                FETCH: begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                end
                DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                MEM_ADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                MEM_READ: adr_src = 1'b1;
                MEM_WB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                MEM_WRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_op    = alu_op_for(funct3, funct7[5]);
                end
                EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = alu_op_for(funct3, (funct3 == 3'b101) && funct7[5]);
                end
                ALU_WB: reg_write = 1'b1;
                BRANCH: begin
                    alu_src_a = 2'b10;
                    // BEQ/BGE/BGEU take the branch on zero, the rest on !zero
                    alu_op    = !funct3[2] ? ALU_SUB : (!funct3[1] ? ALU_SLT : ALU_SLTU);
                    pc_write  = ((funct3 == 3'b000) || (funct3 == 3'b101) || (funct3 == 3'b111))
                                ? zero : !zero;
                end
                JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                end
                ILLEGAL: illegal = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_fsm.sv
// Directed bench for alu_control_fsm: per-instruction state walks with the full
// control word checked every cycle, plus async-reset and trap scenarios.
module tb_alu_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic        adr_src;
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem_write;
    logic        illegal;
    logic [3:0]  state;
    logic [15:0] ctl_now;

    int errors = 0;
    int checks = 0;

    alu_control_fsm #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .adr_src(adr_src), .pc_write(pc_write),
        .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign ctl_now = {alu_op, alu_src_a, alu_src_b, result_src,
                      adr_src, pc_write, ir_write, reg_write, mem_write, illegal};

    // Packs an expected control word in the same field order as ctl_now
    function automatic logic [15:0] ctl(input logic [3:0] op, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] rs,
                                        input logic adr, input logic pcw, input logic irw,
                                        input logic rw, input logic mw, input logic ill);
        return {op, a, b, rs, adr, pcw, irw, rw, mw, ill};
    endfunction

    localparam logic [15:0] C_NONE   = 16'h0000;
    localparam logic [15:0] C_FETCH  = {4'd0, 2'd0, 2'd2, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] C_DECODE = {4'd0, 2'd1, 2'd1, 2'd0, 6'b0};
    localparam logic [15:0] C_ALUWB  = {4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [15:0] C_ILL    = 16'h0001;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr = 32'h002081B3;
        zero = 1'b0;
        repeat (3) step();
        checks++;
        if (state !== 4'd0 || ctl_now !== C_NONE) begin
            errors++;
            $display("FAIL reset_hold state=%0d ctl=%h required state=0 ctl=%h", state, ctl_now, C_NONE);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || ctl_now !== C_FETCH) begin
            errors++;
            $display("FAIL reset_release state=%0d ctl=%h required state=0 ctl=%h", state, ctl_now, C_FETCH);
        end
    endtask

    task automatic test_add();
        logic [3:0]  es [4] = '{4'd1, 4'd6, 4'd8, 4'd0};
        logic [15:0] ec [4];
        ec = '{C_DECODE, ctl(4'd0, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0), C_ALUWB, C_FETCH};
        instr = 32'h002081B3;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (state !== es[i] || ctl_now !== ec[i]) begin
                errors++;
                $display("FAIL add_cyc%0d state=%0d ctl=%h required state=%0d ctl=%h", i, state, ctl_now, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_sub_srai();
        logic [31:0] ins [2] = '{32'h402081B3, 32'h4030D093};
        logic [3:0]  ex_state [2] = '{4'd6, 4'd7};
        logic [15:0] ex_ctl [2];
        logic [3:0]  es [4];
        logic [15:0] ec [4];
        ex_ctl = '{ctl(4'd1, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0),
                   ctl(4'd7, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0)};
        for (int k = 0; k < 2; k++) begin
            instr = ins[k];
            es = '{4'd1, ex_state[k], 4'd8, 4'd0};
            ec = '{C_DECODE, ex_ctl[k], C_ALUWB, C_FETCH};
            for (int i = 0; i < 4; i++) begin
                step();
                checks++;
                if (state !== es[i] || ctl_now !== ec[i]) begin
                    errors++;
                    $display("FAIL subsrai_%0d_cyc%0d state=%0d ctl=%h required state=%0d ctl=%h", k, i, state, ctl_now, es[i], ec[i]);
                end
            end
        end
    endtask

    task automatic test_load_store();
        logic [3:0]  es [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [15:0] ec [5];
        logic [3:0]  ss [4] = '{4'd1, 4'd2, 4'd5, 4'd0};
        logic [15:0] sc [4];
        logic [15:0] c_adr;
        c_adr = ctl(4'd0, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0);
        ec = '{C_DECODE, c_adr, ctl(4'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0),
               ctl(4'd0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 1, 0, 0), C_FETCH};
        sc = '{C_DECODE, c_adr, ctl(4'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 1, 0), C_FETCH};
        instr = 32'h0080A283;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (state !== es[i] || ctl_now !== ec[i]) begin
                errors++;
                $display("FAIL lw_cyc%0d state=%0d ctl=%h required state=%0d ctl=%h", i, state, ctl_now, es[i], ec[i]);
            end
        end
        instr = 32'h0020A423;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (state !== ss[i] || ctl_now !== sc[i]) begin
                errors++;
                $display("FAIL sw_cyc%0d state=%0d ctl=%h required state=%0d ctl=%h", i, state, ctl_now, ss[i], sc[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [2] = '{32'h00208463, 32'h0020C463};
        logic [3:0]  ops [2] = '{4'd1, 4'd8};
        logic        take_on_zero [2] = '{1'b1, 1'b0};
        logic [15:0] exp;
        for (int k = 0; k < 2; k++) begin
            instr = ins[k];
            zero = 1'b1;
            step();
            checks++;
            if (state !== 4'd1 || ctl_now !== C_DECODE) begin
                errors++;
                $display("FAIL br%0d_decode state=%0d ctl=%h required state=1 ctl=%h", k, state, ctl_now, C_DECODE);
            end
            step();
            for (int z = 1; z >= 0; z--) begin
                zero = z[0];
                #1;
                exp = ctl(ops[k], 2'd2, 2'd0, 2'd0, 0, (z[0] == take_on_zero[k]), 0, 0, 0, 0);
                checks++;
                if (state !== 4'd9 || ctl_now !== exp) begin
                    errors++;
                    $display("FAIL br%0d_zero%0d state=%0d ctl=%h required state=9 ctl=%h", k, z, state, ctl_now, exp);
                end
            end
            step();
            checks++;
            if (state !== 4'd0 || ctl_now !== C_FETCH) begin
                errors++;
                $display("FAIL br%0d_fetch state=%0d ctl=%h required state=0 ctl=%h", k, state, ctl_now, C_FETCH);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal_lui();
        logic [31:0] ins [2] = '{32'h0000006F, 32'h000000B7};
        logic [3:0]  ex_state [2] = '{4'd10, 4'd11};
        logic [15:0] ex_ctl [2];
        logic [3:0]  es [4];
        logic [15:0] ec [4];
        ex_ctl = '{ctl(4'd0, 2'd1, 2'd2, 2'd0, 0, 1, 0, 0, 0, 0),
                   ctl(4'd0, 2'd3, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0)};
        for (int k = 0; k < 2; k++) begin
            instr = ins[k];
            es = '{4'd1, ex_state[k], 4'd8, 4'd0};
            ec = '{C_DECODE, ex_ctl[k], C_ALUWB, C_FETCH};
            for (int i = 0; i < 4; i++) begin
                step();
                checks++;
                if (state !== es[i] || ctl_now !== ec[i]) begin
                    errors++;
                    $display("FAIL jallui_%0d_cyc%0d state=%0d ctl=%h required state=%0d ctl=%h", k, i, state, ctl_now, es[i], ec[i]);
                end
            end
        end
    endtask

    // Illegal funct fields: R-type alt funct7 on SLL, SLLI with alt funct7, branch funct3 010
    task automatic test_illegal_funct();
        logic [31:0] ins [3] = '{32'h40209033, 32'h40209013, 32'h0020A463};
        for (int k = 0; k < 3; k++) begin
            instr = ins[k];
            step();
            step();
            checks++;
            if (state !== 4'd15 || ctl_now !== C_ILL) begin
                errors++;
                $display("FAIL illfunct_%0d state=%0d ctl=%h required state=15 ctl=%h", k, state, ctl_now, C_ILL);
            end
            rst = 1'b1;
            step();
            rst = 1'b0;
            #1;
        end
    endtask

    task automatic test_reset_mid_exec();
        instr = 32'h002081B3;
        step();
        step();
        checks++;
        if (state !== 4'd6) begin
            errors++;
            $display("FAIL midexec_reach state=%0d required=6", state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || ctl_now !== C_NONE) begin
            errors++;
            $display("FAIL midexec_async state=%0d ctl=%h required state=0 ctl=%h", state, ctl_now, C_NONE);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (state !== 4'd0 || reg_write !== 1'b0) begin
                errors++;
                $display("FAIL midexec_hold%0d state=%0d reg_write=%0b required state=0 reg_write=0", i, state, reg_write);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || ctl_now !== C_FETCH) begin
            errors++;
            $display("FAIL midexec_restart state=%0d ctl=%h required state=0 ctl=%h", state, ctl_now, C_FETCH);
        end
    endtask

    task automatic test_illegal();
        instr = 32'h0000000B;
        step();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL ill_decode state=%0d required=1", state);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (state !== 4'd15 || ctl_now !== C_ILL) begin
                errors++;
                $display("FAIL ill_stay%0d state=%0d ctl=%h required state=15 ctl=%h", i, state, ctl_now, C_ILL);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0 || ctl_now !== C_NONE) begin
            errors++;
            $display("FAIL ill_async_reset state=%0d ctl=%h required state=0 ctl=%h", state, ctl_now, C_NONE);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || ctl_now !== C_FETCH) begin
            errors++;
            $display("FAIL ill_restart state=%0d ctl=%h required state=0 ctl=%h", state, ctl_now, C_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_srai();
        test_load_store();
        test_branch();
        test_jal_lui();
        test_illegal_funct();
        test_reset_mid_exec();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
